// File: rtl/mtr_pkg.sv
// Shared types and constants for the motor ramp controller.
package mtr_pkg;

  localparam int SPD_W = 12;

  typedef logic signed [SPD_W-1:0] spd_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RAMP    = 2'd1,
    ST_FAULT   = 2'd2,
    ST_RECOVER = 2'd3
  } ramp_state_t;

  localparam spd_t SPD_MAX = spd_t'(2047);
  localparam spd_t SPD_MIN = spd_t'(-2048);

endpackage

// File: rtl/spd_slew.sv
// Combinational slew step for one motor side: moves the current speed
// toward the target by at most STEP counts and flags arrival.
module spd_slew
  import mtr_pkg::*;
#(
  parameter int STEP = 16
) (
  input  spd_t i_cur,
  input  spd_t i_tgt,
  output spd_t o_nxt,
  output logic o_at_tgt
);

  localparam logic signed [12:0] STEP_W = 13'(STEP);
  localparam spd_t               STEP_S = spd_t'(STEP);

  logic signed [12:0] w_diff;
  logic signed [12:0] w_mag;

  // A full step never passes the target (|diff| > STEP), so the 12-bit
  // sum cannot wrap even at the -2048/2047 extremes.
  function automatic spd_t step_toward(input spd_t cur, input spd_t tgt,
                                       input logic signed [12:0] diff,
                                       input logic signed [12:0] mag);
    if (mag <= STEP_W)
      return tgt;
    else if (diff[12])
      return cur - STEP_S;
    else
      return cur + STEP_S;
  endfunction

  // 13-bit difference covers the full 12-bit span without overflow.
  assign w_diff   = $signed({i_tgt[11], i_tgt}) - $signed({i_cur[11], i_cur});
  assign w_mag    = w_diff[12] ? -w_diff : w_diff;
  assign o_nxt    = step_toward(i_cur, i_tgt, w_diff, w_mag);
  assign o_at_tgt = (o_nxt == i_tgt);

endmodule

// File: rtl/mtr_ramp_ctrl.sv
// Slew-rate controller ahead of the motor driver: steps left/right speed
// commands toward accepted targets once per PWM period, zeroes them on a
// fault and holds off new targets for HOLDOFF periods afterwards.
module mtr_ramp_ctrl
  import mtr_pkg::*;
#(
  parameter int STEP    = 16,
  parameter int HOLDOFF = 32
) (
  input  logic clk,
  input  logic rst,
  input  spd_t tgt_lft,
  input  spd_t tgt_rght,
  input  logic tgt_vld,
  output logic tgt_rdy,
  input  logic pwm_synch,
  input  logic fault,
  output spd_t lft_spd,
  output spd_t rght_spd,
  output logic ramp_done,
  output logic busy
);

  ramp_state_t r_state;
  ramp_state_t w_state_nxt;

  spd_t       r_lft_spd;
  spd_t       r_rght_spd;
  spd_t       r_tgt_lft;
  spd_t       r_tgt_rght;
  logic [7:0] r_cnt;
  logic       r_done;

  spd_t w_lft_nxt;
  spd_t w_rght_nxt;
  logic w_lft_at;
  logic w_rght_at;
  logic w_xfer;
  logic w_load_tgt;
  logic w_step;
  logic w_clr;
  logic w_load_cnt;
  logic w_dec_cnt;
  logic w_done_nxt;

  spd_slew #(.STEP(STEP)) u_slew_lft (
    .i_cur   (r_lft_spd),
    .i_tgt   (r_tgt_lft),
    .o_nxt   (w_lft_nxt),
    .o_at_tgt(w_lft_at)
  );

  spd_slew #(.STEP(STEP)) u_slew_rght (
    .i_cur   (r_rght_spd),
    .i_tgt   (r_tgt_rght),
    .o_nxt   (w_rght_nxt),
    .o_at_tgt(w_rght_at)
  );

  assign tgt_rdy = (r_state == ST_IDLE) || (r_state == ST_RAMP);
  assign busy    = (r_state != ST_IDLE);
  assign w_xfer  = tgt_vld && tgt_rdy;

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Next-state and datapath control; fault overrides everything but reset.
  always_comb begin
    w_state_nxt = r_state;
    w_load_tgt  = 1'b0;
    w_step      = 1'b0;
    w_clr       = 1'b0;
    w_load_cnt  = 1'b0;
    w_dec_cnt   = 1'b0;
    w_done_nxt  = 1'b0;
    if (fault) begin
      w_state_nxt = ST_FAULT;
      w_clr       = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            w_load_tgt  = 1'b1;
            w_state_nxt = ST_RAMP;
          end
        end
        ST_RAMP: begin
          w_load_tgt = w_xfer;
          if (pwm_synch) begin
            w_step = 1'b1;
            // A target arriving on the completing period keeps us ramping
            // so the freshly accepted target is not stranded.
            if (w_lft_at && w_rght_at) begin
              w_done_nxt  = 1'b1;
              w_state_nxt = w_xfer ? ST_RAMP : ST_IDLE;
            end
          end
        end
        ST_FAULT: begin
          w_load_cnt  = 1'b1;
          w_state_nxt = ST_RECOVER;
        end
        ST_RECOVER: begin
          if (r_cnt == 8'd0)
            w_state_nxt = ST_IDLE;
          else if (pwm_synch)
            w_dec_cnt = 1'b1;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Speed, target and hold-off registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lft_spd  <= '0;
      r_rght_spd <= '0;
      r_tgt_lft  <= '0;
      r_tgt_rght <= '0;
      r_cnt      <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      if (w_clr) begin
        r_lft_spd  <= '0;
        r_rght_spd <= '0;
        r_tgt_lft  <= '0;
        r_tgt_rght <= '0;
      end else begin
        if (w_step) begin
          r_lft_spd  <= w_lft_nxt;
          r_rght_spd <= w_rght_nxt;
        end
        if (w_load_tgt) begin
          r_tgt_lft  <= tgt_lft;
          r_tgt_rght <= tgt_rght;
        end
      end
      if (w_load_cnt)
        r_cnt <= 8'(HOLDOFF);
      else if (w_dec_cnt)
        r_cnt <= r_cnt - 8'd1;
    end
  end

  assign lft_spd   = r_lft_spd;
  assign rght_spd  = r_rght_spd;
  assign ramp_done = r_done;

endmodule
